// File: rtl/xalu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble sequencer: xalu function codes, FSM state
// encoding and a small helper used by both the RTL and the bench.
package xalu_nibble_sequencer_pkg;

  localparam logic [2:0] FN_ADD   = 3'd0;
  localparam logic [2:0] FN_AND   = 3'd1;
  localparam logic [2:0] FN_OR    = 3'd2;
  localparam logic [2:0] FN_XOR   = 3'd3;
  localparam logic [2:0] FN_PASSA = 3'd4;
  localparam logic [2:0] FN_PASSB = 3'd5;
  localparam logic [2:0] FN_SHR   = 3'd6;
  localparam logic [2:0] FN_SHL   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Functions whose right-hand carry chain is seeded with cin and whose final
  // co_left is reported as cout.
  function automatic logic uses_left_carry(input logic [2:0] f);
    return (f == FN_ADD) || (f == FN_SHL);
  endfunction

endpackage

// File: rtl/xalu_nibble_sequencer_if.sv
// Bundle of the sequencer's host-side request/result signals and its link to
// the external 4-bit xalu slice.
//   slave  : the sequencer (takes requests, drives the slice inputs)
//   master : host plus slice environment (drives requests, slice outputs)
interface xalu_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();

  // Host side
  logic             start;
  logic [2:0]       func;
  logic             com;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             neg_zero;
  logic             equ;

  // Slice side
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_f;
  logic             alu_com;
  logic             alu_ci_left;
  logic             alu_ci_right;
  logic [3:0]       alu_d;
  logic             alu_co_left;
  logic             alu_co_right;
  logic             alu_equ;

  modport slave (
    input  start, func, com, cin, a, b,
    input  alu_d, alu_co_left, alu_co_right, alu_equ,
    output busy, done, result, cout, zero, neg_zero, equ,
    output alu_a, alu_b, alu_f, alu_com, alu_ci_left, alu_ci_right
  );

  modport master (
    output start, func, com, cin, a, b,
    output alu_d, alu_co_left, alu_co_right, alu_equ,
    input  busy, done, result, cout, zero, neg_zero, equ,
    input  alu_a, alu_b, alu_f, alu_com, alu_ci_left, alu_ci_right
  );

endinterface

// File: rtl/xalu_nibble_sequencer.sv
// Multi-cycle controller that runs WIDTH-bit operations through one external
// combinational 4-bit xalu slice, one nibble per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - xalu_nibble_sequencer_if.slave: start/func/com/cin/a/b request,
//          busy/done/result/cout/zero/neg_zero/equ status, alu_* slice link.
// WIDTH must match the interface instance's WIDTH (multiple of 4, >= 8).
// Timing: accept edge -> NIB RUN cycles -> one DONE cycle; done pulses in the
// cycle after DONE (NIB+1 edges after accept), which is already IDLE.
module xalu_nibble_sequencer
  import xalu_nibble_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  xalu_nibble_sequencer_if.slave bus
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [2:0]       func_q;
  logic             com_q, cin_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic             equ_acc_q;
  logic             busy_q, done_q, cout_q, zero_q, neg_zero_q, equ_q;

  logic             accept, run, finish;
  logic             is_shr, first;
  logic [IDXW-1:0]  pos;
  logic [3:0]       alu_a, alu_b;
  logic             alu_ci_left, alu_ci_right;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control logic. Slice drives depend only on registered state so
  // they are stable for the whole cycle and hold after the operation.
  always_comb begin
    accept = (state_q == S_IDLE) && bus.start;
    run    = (state_q == S_RUN);
    finish = (state_q == S_DONE);
    is_shr = (func_q == FN_SHR);
    first  = (idx_q == '0);
    // SHR walks from the top nibble down so the fill bit enters at the MSB.
    pos    = is_shr ? (LAST_IDX - idx_q) : idx_q;
    alu_a  = a_q[{pos, 2'b00} +: 4];
    alu_b  = b_q[{pos, 2'b00} +: 4];
    alu_ci_left  = 1'b0;
    alu_ci_right = 1'b0;
    if (is_shr) begin
      alu_ci_left = first ? cin_q : carry_q;
    end else if (first) begin
      alu_ci_right = uses_left_carry(func_q) ? cin_q : 1'b0;
    end else begin
      alu_ci_right = carry_q;
    end
  end

  // Operand latch, nibble collection, carry chain and flag reduction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      func_q     <= FN_ADD;
      com_q      <= 1'b0;
      cin_q      <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      equ_acc_q  <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_zero_q <= 1'b0;
      equ_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        func_q    <= bus.func;
        com_q     <= bus.com;
        cin_q     <= bus.cin;
        idx_q     <= '0;
        carry_q   <= 1'b0;
        acc_q     <= '0;
        equ_acc_q <= 1'b1;
        busy_q    <= 1'b1;
      end
      if (run) begin
        acc_q[{pos, 2'b00} +: 4] <= bus.alu_d;
        // Carries come from the slice uninverted, so COM never disturbs them.
        carry_q   <= is_shr ? bus.alu_co_right : bus.alu_co_left;
        equ_acc_q <= equ_acc_q & bus.alu_equ;
        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
      end
      if (finish) begin
        result_q   <= acc_q;
        zero_q     <= (acc_q == '0);
        neg_zero_q <= (acc_q == '1);
        equ_q      <= equ_acc_q;
        cout_q     <= (uses_left_carry(func_q) || is_shr) ? carry_q : 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.cout         = cout_q;
  assign bus.zero         = zero_q;
  assign bus.neg_zero     = neg_zero_q;
  assign bus.equ          = equ_q;
  assign bus.alu_a        = alu_a;
  assign bus.alu_b        = alu_b;
  assign bus.alu_f        = func_q;
  assign bus.alu_com      = com_q;
  assign bus.alu_ci_left  = alu_ci_left;
  assign bus.alu_ci_right = alu_ci_right;

endmodule
